riscv_trace_classifier: RTL and testbench
=========================================

Name: riscv_trace_classifier

Overview:
- Parametrised run-time instruction classifier and profiler attached to the retire stage.
- Matches every retired instruction word against NUM_CLASSES programmable mask/match pairs and keeps a saturating counter per class.
- Pushes matched events into a small trace FIFO drained by a ready/valid consumer (trace printer or debug module).
- Replaces fixed compile-time instruction masks with programmable, counted and buffered classification.

Parameters:
- NUM_CLASSES, 8, number of mask/match comparator slots (2..32).
- CNT_WIDTH, 32, width of each per-class, unmatched and drop counter (4..64).
- FIFO_DEPTH, 4, trace FIFO entries; power of two, >=2.
- CLS_W, $clog2(NUM_CLASSES), derived index width; not to be overridden.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- instr_valid_i  in  1  one instruction retires this cycle
- instr_rdata_i  in  32  retired instruction word (uncompressed)
- pc_i  in  32  PC of retired instruction
- cfg_we_i  in  1  write one class slot
- cfg_idx_i  in  CLS_W  slot index for write
- cfg_mask_i  in  32  mask value
- cfg_match_i  in  32  match value
- cfg_en_i  in  1  slot enable value
- cnt_clear_i  in  1  clear all counters
- cnt_freeze_i  in  1  hold counters and inhibit FIFO pushes
- cnt_idx_i  in  CLS_W  counter read select
- cnt_value_o  out  CNT_WIDTH  counter[cnt_idx_i], combinational from registers
- unmatched_cnt_o  out  CNT_WIDTH  retired instructions hitting no enabled slot
- drop_cnt_o  out  CNT_WIDTH  events lost because the FIFO was full
- trace_valid_o  out  1  FIFO head valid
- trace_ready_i  in  1  consumer accepts head
- trace_class_o  out  CLS_W  class of head entry
- trace_pc_o  out  32  PC of head entry
- trace_instr_o  out  32  instruction of head entry

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset state: all mask, match and en = 0. All counters = 0. FIFO empty. trace_valid_o = 0 and trace_* = 0.
- Reset mid-operation:
  - Takes effect immediately without a clock edge.
  - trace_valid_o drops asynchronously.
  - Entries in flight are lost.
- Hit rule: hit[k] = en[k] && ((instr_rdata_i & mask[k]) == match[k]), evaluated only when instr_valid_i = 1.
- Configuration:
  - A cfg_we_i write updates slot cfg_idx_i at the clock edge.
  - An instruction retiring in the same cycle uses the old configuration.
  - cfg_idx_i >= NUM_CLASSES: the write is ignored.
- Counters:
  - Every k with hit[k] increments counter[k]; overlapping slots all count.
  - No hit: unmatched_cnt increments.
  - All counters saturate at 2^CNT_WIDTH-1 and never wrap.
  - Updated values are visible on outputs the cycle after the event.
- Priority per cycle: cnt_clear_i > cnt_freeze_i > increment.
  - cnt_clear_i zeroes per-class, unmatched and drop counters; a same-cycle event is not counted. The FIFO is not flushed.
  - cnt_freeze_i holds all counters, blocks FIFO pushes and does not count drops. FIFO pops continue.
- FIFO push:
  - Condition: any hit, and freeze inactive.
  - Entry = {lowest hitting index, pc_i, instr_rdata_i}.
  - Entry appears at the head no earlier than the next cycle. On an empty FIFO, trace_valid_o rises exactly 1 cycle after the event.
- FIFO pop: occurs when trace_valid_o && trace_ready_i. Head outputs are stable while valid && !ready.
- Full-FIFO rules:
  - Push with no pop: the entry is dropped and drop_cnt increments (saturating).
  - Push and pop in the same cycle: both succeed and occupancy is unchanged.
- Empty FIFO: trace_ready_i is ignored.
- Pointers: read/write pointers wrap modulo FIFO_DEPTH. Occupancy is tracked with an extra pointer bit.
- Implementation target: no combinational path from instr_* to trace_* outputs.

Test Plan:
- Program slot0 mask 0x0000707F / match 0x00000013 (ADDI) and slot1 mask 0x7F / match 0x6F (JAL), both enabled. Retire 0x00100093 then 0x0000006F. Required:
  - counter0 = 1, counter1 = 1, unmatched = 0.
  - Trace entries in order: class 0 then class 1, with correct PCs.
- Enable slot2 mask 0x7F / match 0x13 (OPIMM). Retire ADDI 0x00100093. Required: counter0 and counter2 both increment; FIFO entry class = 0.
- FIFO_DEPTH = 4, trace_ready_i = 0, 6 consecutive hits. Required:
  - 4 entries held, drop_cnt = 2.
  - Then raise ready on a full FIFO while a 7th hit arrives: pop and push both occur, occupancy stays 4, drop_cnt stays 2.
- CNT_WIDTH = 4, 17 ADDI hits. Required: counter0 = 15 (saturated). Then assert cnt_clear_i in the same cycle as a hit: counter0 = 0 next cycle.
- Two same-cycle cases:
  - cfg_we_i disables slot0 in the same cycle ADDI retires: counter0 increments (old config applies); the next ADDI counts as unmatched.
  - cnt_freeze_i = 1 during 3 hits: no counter change and no FIFO push.
- Assert rst_n low between clock edges while the FIFO holds 2 entries. Required: trace_valid_o = 0 immediately, all counters 0, and after release an ADDI is counted only if slots are reprogrammed.

Source files
------------

// File: rtl/riscv_trace_classifier_if.sv
// ---------------------------------------------------------------------------
// riscv_trace_classifier_if
//
// Purpose : ready/valid trace bus between the instruction classifier (master,
//           producer of trace entries) and a trace consumer (slave), such as
//           a trace printer or a debug module.
//
// Signals : trace_valid_o  head entry of the trace FIFO is valid
//           trace_ready_i  consumer accepts the head entry this cycle
//           trace_class_o  lowest matching class index of the head entry
//           trace_pc_o     PC of the head entry
//           trace_instr_o  instruction word of the head entry
//
// The _o/_i suffixes are seen from the classifier side.
// ---------------------------------------------------------------------------
interface riscv_trace_classifier_if #(
    parameter int CLS_W = 3
);
    logic             trace_valid_o;
    logic             trace_ready_i;
    logic [CLS_W-1:0] trace_class_o;
    logic [31:0]      trace_pc_o;
    logic [31:0]      trace_instr_o;

    modport master (
        output trace_valid_o,
        output trace_class_o,
        output trace_pc_o,
        output trace_instr_o,
        input  trace_ready_i
    );

    modport slave (
        input  trace_valid_o,
        input  trace_class_o,
        input  trace_pc_o,
        input  trace_instr_o,
        output trace_ready_i
    );
endinterface

// File: rtl/riscv_trace_classifier.sv
// ---------------------------------------------------------------------------
// riscv_trace_classifier
//
// Purpose : run-time instruction classifier and profiler at the retire stage.
//           Every retired instruction word is compared against NUM_CLASSES
//           programmable mask/match slots. Each slot keeps a saturating hit
//           counter; instructions hitting no enabled slot are counted as
//           unmatched. Matched instructions are pushed into a small trace
//           FIFO drained over a ready/valid bus; pushes that find the FIFO
//           full are counted as drops.
//
// Ports   : clk, rst_n                 clock, asynchronous active-low reset
//           instr_valid_i/rdata_i/pc_i retire port
//           cfg_we_i/idx_i/mask_i/match_i/en_i   slot programming
//           cnt_clear_i                zero all counters (highest priority)
//           cnt_freeze_i               hold counters, block FIFO pushes
//           cnt_idx_i / cnt_value_o    per-class counter read-back
//           unmatched_cnt_o            no-hit instruction count
//           drop_cnt_o                 trace entries lost to a full FIFO
//           trace_if (master)          trace FIFO head, ready/valid
// ---------------------------------------------------------------------------
module riscv_trace_classifier #(
    parameter int NUM_CLASSES = 8,
    parameter int CNT_WIDTH   = 32,
    parameter int FIFO_DEPTH  = 4,
    parameter int CLS_W       = $clog2(NUM_CLASSES)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 instr_valid_i,
    input  logic [31:0]          instr_rdata_i,
    input  logic [31:0]          pc_i,
    input  logic                 cfg_we_i,
    input  logic [CLS_W-1:0]     cfg_idx_i,
    input  logic [31:0]          cfg_mask_i,
    input  logic [31:0]          cfg_match_i,
    input  logic                 cfg_en_i,
    input  logic                 cnt_clear_i,
    input  logic                 cnt_freeze_i,
    input  logic [CLS_W-1:0]     cnt_idx_i,
    output logic [CNT_WIDTH-1:0] cnt_value_o,
    output logic [CNT_WIDTH-1:0] unmatched_cnt_o,
    output logic [CNT_WIDTH-1:0] drop_cnt_o,
    riscv_trace_classifier_if.master trace_if
);

    localparam int AW      = $clog2(FIFO_DEPTH);
    localparam int ENTRY_W = CLS_W + 64;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        sat_inc = (&v) ? v : v + CNT_WIDTH'(1);
    endfunction

    logic [NUM_CLASSES-1:0] hit;
    logic [CNT_WIDTH-1:0]   cls_cnt [NUM_CLASSES];

    // -----------------------------------------------------------------------
    // Per-slot configuration, comparator and hit counter
    // -----------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < NUM_CLASSES; gi++) begin : g_slot
            logic [31:0]          mask_q,  mask_d;
            logic [31:0]          match_q, match_d;
            logic                 en_q,    en_d;
            logic [CNT_WIDTH-1:0] cnt_q,   cnt_d;
            logic                 cfg_sel;

            // Indices that do not name a slot decode to no slot at all, so
            // out-of-range writes fall away without an explicit range check.
            assign cfg_sel = cfg_we_i && (cfg_idx_i == CLS_W'(gi));

            // The comparator sees the registered configuration, so a write
            // in the same cycle as a retirement only affects later ones.
            assign hit[gi] = instr_valid_i && en_q &&
                             ((instr_rdata_i & mask_q) == match_q);

            always_comb begin
                mask_d  = mask_q;
                match_d = match_q;
                en_d    = en_q;
                if (cfg_sel) begin
                    mask_d  = cfg_mask_i;
                    match_d = cfg_match_i;
                    en_d    = cfg_en_i;
                end
            end

            always_comb begin
                cnt_d = cnt_q;
                if (cnt_clear_i) begin
                    cnt_d = '0;
                end else if (!cnt_freeze_i && hit[gi]) begin
                    cnt_d = sat_inc(cnt_q);
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    mask_q  <= '0;
                    match_q <= '0;
                    en_q    <= 1'b0;
                    cnt_q   <= '0;
                end else begin
                    mask_q  <= mask_d;
                    match_q <= match_d;
                    en_q    <= en_d;
                    cnt_q   <= cnt_d;
                end
            end

            assign cls_cnt[gi] = cnt_q;
        end
    endgenerate

    // Counter read-back; a select beyond the last slot reads zero.
    always_comb begin
        cnt_value_o = '0;
        for (int k = 0; k < NUM_CLASSES; k++) begin
            if (cnt_idx_i == CLS_W'(k)) begin
                cnt_value_o = cls_cnt[k];
            end
        end
    end

    // -----------------------------------------------------------------------
    // Lowest hitting slot: scan downwards so the smallest index wins.
    // -----------------------------------------------------------------------
    logic [CLS_W-1:0] hit_idx;
    logic             any_hit;

    always_comb begin
        hit_idx = '0;
        for (int k = NUM_CLASSES - 1; k >= 0; k--) begin
            if (hit[k]) begin
                hit_idx = CLS_W'(k);
            end
        end
    end

    assign any_hit = |hit;

    // -----------------------------------------------------------------------
    // Trace FIFO. Pointers carry one extra bit so full and empty are
    // distinguishable when the index bits coincide.
    // -----------------------------------------------------------------------
    logic [AW:0]          wr_ptr_q, wr_ptr_d;
    logic [AW:0]          rd_ptr_q, rd_ptr_d;
    logic [ENTRY_W-1:0]   mem_q [FIFO_DEPTH];
    logic [ENTRY_W-1:0]   wr_entry_d;
    logic [ENTRY_W-1:0]   head;
    logic                 fifo_empty, fifo_full;
    logic                 push_req, push, pop, drop;

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    assign push_req = any_hit && !cnt_freeze_i;
    assign pop      = !fifo_empty && trace_if.trace_ready_i;
    // On a full FIFO a simultaneous pop frees the slot being written.
    assign push     = push_req && (!fifo_full || pop);
    assign drop     = push_req && fifo_full && !pop;

    assign wr_entry_d = {hit_idx, pc_i, instr_rdata_i};

    // Storage has no reset: validity is carried entirely by the pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wr_entry_d;
        end
    end

    // The head is read straight from the storage registers so a pushed
    // entry is visible one cycle after the retirement; there is no path
    // from the retire port to the trace outputs.
    assign head = mem_q[rd_ptr_q[AW-1:0]];

    // -----------------------------------------------------------------------
    // Unmatched / drop counters and pointer update
    // -----------------------------------------------------------------------
    logic [CNT_WIDTH-1:0] unmatched_q, unmatched_d;
    logic [CNT_WIDTH-1:0] drop_q, drop_d;

    always_comb begin
        unmatched_d = unmatched_q;
        drop_d      = drop_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;

        if (cnt_clear_i) begin
            unmatched_d = '0;
            drop_d      = '0;
        end else if (!cnt_freeze_i) begin
            if (instr_valid_i && !any_hit) begin
                unmatched_d = sat_inc(unmatched_q);
            end
            if (drop) begin
                drop_d = sat_inc(drop_q);
            end
        end

        if (push) begin
            wr_ptr_d = wr_ptr_q + (AW + 1)'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + (AW + 1)'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            unmatched_q <= '0;
            drop_q      <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
        end else begin
            unmatched_q <= unmatched_d;
            drop_q      <= drop_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
        end
    end

    assign unmatched_cnt_o = unmatched_q;
    assign drop_cnt_o      = drop_q;

    // Head fields read as zero whenever the FIFO is empty, including while
    // reset is asserted, since the storage itself is never cleared.
    assign trace_if.trace_valid_o = !fifo_empty;
    assign trace_if.trace_class_o = fifo_empty ? '0 : head[ENTRY_W-1 -: CLS_W];
    assign trace_if.trace_pc_o    = fifo_empty ? '0 : head[63:32];
    assign trace_if.trace_instr_o = fifo_empty ? '0 : head[31:0];

endmodule

// File: tb/tb_riscv_trace_classifier.sv
// ---------------------------------------------------------------------------
// tb_riscv_trace_classifier
//
// Directed stimulus against riscv_trace_classifier (8 slots, 4-bit counters,
// 4-entry FIFO). A behavioural model tracks slot configuration, counters and
// the trace queue; a compare process checks every cycle, and literal
// expectations pin specific scenario results.
// ---------------------------------------------------------------------------
module tb_riscv_trace_classifier;

    localparam int NUM     = 8;
    localparam int CW      = 4;
    localparam int DEPTH   = 4;
    localparam int CLS_W   = $clog2(NUM);
    localparam int CNT_MAX = (1 << CW) - 1;

    localparam logic [31:0] ADDI = 32'h0010_0093;
    localparam logic [31:0] JAL  = 32'h0000_006F;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             instr_valid_i;
    logic [31:0]      instr_rdata_i;
    logic [31:0]      pc_i;
    logic             cfg_we_i;
    logic [CLS_W-1:0] cfg_idx_i;
    logic [31:0]      cfg_mask_i;
    logic [31:0]      cfg_match_i;
    logic             cfg_en_i;
    logic             cnt_clear_i;
    logic             cnt_freeze_i;
    logic [CLS_W-1:0] cnt_idx_i;
    logic [CW-1:0]    cnt_value_o;
    logic [CW-1:0]    unmatched_cnt_o;
    logic [CW-1:0]    drop_cnt_o;

    riscv_trace_classifier_if #(.CLS_W(CLS_W)) tif ();

    riscv_trace_classifier #(
        .NUM_CLASSES(NUM),
        .CNT_WIDTH  (CW),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .instr_valid_i  (instr_valid_i),
        .instr_rdata_i  (instr_rdata_i),
        .pc_i           (pc_i),
        .cfg_we_i       (cfg_we_i),
        .cfg_idx_i      (cfg_idx_i),
        .cfg_mask_i     (cfg_mask_i),
        .cfg_match_i    (cfg_match_i),
        .cfg_en_i       (cfg_en_i),
        .cnt_clear_i    (cnt_clear_i),
        .cnt_freeze_i   (cnt_freeze_i),
        .cnt_idx_i      (cnt_idx_i),
        .cnt_value_o    (cnt_value_o),
        .unmatched_cnt_o(unmatched_cnt_o),
        .drop_cnt_o     (drop_cnt_o),
        .trace_if       (tif)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    bit chk_en      = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // -----------------------------------------------------------------------
    // Behavioural model
    // -----------------------------------------------------------------------
    typedef struct packed {
        logic [CLS_W-1:0] cls;
        logic [31:0]      pc;
        logic [31:0]      instr;
    } ent_t;

    bit [31:0] m_mask  [NUM];
    bit [31:0] m_match [NUM];
    bit        m_en    [NUM];
    int        m_cnt   [NUM];
    int        m_unm;
    int        m_drop;
    ent_t      m_q[$];

    function automatic int sat(input int v);
        return (v >= CNT_MAX) ? CNT_MAX : v + 1;
    endfunction

    function automatic bit m_hit(input int k);
        return instr_valid_i && m_en[k] && ((instr_rdata_i & m_mask[k]) == m_match[k]);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM; k++) begin
                m_mask[k] = '0; m_match[k] = '0; m_en[k] = 1'b0; m_cnt[k] = 0;
            end
            m_unm  = 0;
            m_drop = 0;
            m_q.delete();
        end else begin
            int   first;
            ent_t e;
            first = -1;
            for (int k = NUM - 1; k >= 0; k--) begin
                if (m_hit(k)) first = k;
            end
            if (cnt_clear_i) begin
                for (int k = 0; k < NUM; k++) m_cnt[k] = 0;
                m_unm  = 0;
                m_drop = 0;
            end else if (!cnt_freeze_i) begin
                for (int k = 0; k < NUM; k++) begin
                    if (m_hit(k)) m_cnt[k] = sat(m_cnt[k]);
                end
                if (instr_valid_i && first < 0) m_unm = sat(m_unm);
            end
            if (tif.trace_ready_i && m_q.size() > 0) void'(m_q.pop_front());
            if (first >= 0 && !cnt_freeze_i) begin
                e.cls   = CLS_W'(first);
                e.pc    = pc_i;
                e.instr = instr_rdata_i;
                if (m_q.size() < DEPTH) m_q.push_back(e);
                else if (!cnt_clear_i) m_drop = sat(m_drop);
            end
            if (cfg_we_i && int'(cfg_idx_i) < NUM) begin
                m_mask[cfg_idx_i]  = cfg_mask_i;
                m_match[cfg_idx_i] = cfg_match_i;
                m_en[cfg_idx_i]    = cfg_en_i;
            end
        end
    end

    // Per-cycle compare, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("cnt_value", 64'(cnt_value_o), 64'(m_cnt[cnt_idx_i]));
            check("unmatched", 64'(unmatched_cnt_o), 64'(m_unm));
            check("drop", 64'(drop_cnt_o), 64'(m_drop));
            check("trace_valid", 64'(tif.trace_valid_o), 64'(m_q.size() > 0));
            if (m_q.size() > 0) begin
                check("trace_class", 64'(tif.trace_class_o), 64'(m_q[0].cls));
                check("trace_pc", 64'(tif.trace_pc_o), 64'(m_q[0].pc));
                check("trace_instr", 64'(tif.trace_instr_o), 64'(m_q[0].instr));
            end
        end
    end

    // -----------------------------------------------------------------------
    // Stimulus helpers
    // -----------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic retire(input logic [31:0] ins, input logic [31:0] pc);
        instr_valid_i = 1'b1;
        instr_rdata_i = ins;
        pc_i          = pc;
        $display("retire pc=%08h instr=%08h clr=%0b frz=%0b rdy=%0b",
                 pc, ins, cnt_clear_i, cnt_freeze_i, tif.trace_ready_i);
        tick();
        instr_valid_i = 1'b0;
    endtask

    task automatic program_slot(input int idx, input logic [31:0] mask,
                                input logic [31:0] match, input logic en);
        cfg_we_i    = 1'b1;
        cfg_idx_i   = CLS_W'(idx);
        cfg_mask_i  = mask;
        cfg_match_i = match;
        cfg_en_i    = en;
        $display("cfg slot=%0d mask=%08h match=%08h en=%0b", idx, mask, match, en);
        tick();
        cfg_we_i = 1'b0;
    endtask

    task automatic peek_cnt(input string name, input int idx, input int exp);
        @(negedge clk);
        #1;
        cnt_idx_i = CLS_W'(idx);
        #1;
        check(name, 64'(cnt_value_o), 64'(exp));
    endtask

    task automatic pop_expect(input string name, input int cls, input logic [31:0] pc,
                              input logic [31:0] ins);
        check({name, "_valid"}, 64'(tif.trace_valid_o), 64'(1));
        check({name, "_class"}, 64'(tif.trace_class_o), 64'(cls));
        check({name, "_pc"}, 64'(tif.trace_pc_o), 64'(pc));
        check({name, "_instr"}, 64'(tif.trace_instr_o), 64'(ins));
        $display("pop class=%0d pc=%08h instr=%08h", tif.trace_class_o,
                 tif.trace_pc_o, tif.trace_instr_o);
        tif.trace_ready_i = 1'b1;
        tick();
        tif.trace_ready_i = 1'b0;
    endtask

    // -----------------------------------------------------------------------
    // Directed sequence
    // -----------------------------------------------------------------------
    initial begin
        rst_n = 1'b0; instr_valid_i = 1'b0; instr_rdata_i = '0; pc_i = '0;
        cfg_we_i = 1'b0; cfg_idx_i = '0; cfg_mask_i = '0; cfg_match_i = '0;
        cfg_en_i = 1'b0; cnt_clear_i = 1'b0; cnt_freeze_i = 1'b0; cnt_idx_i = '0;
        tif.trace_ready_i = 1'b0;

        // Reset state
        tick();
        tick();
        check("rst_valid", 64'(tif.trace_valid_o), 64'(0));
        check("rst_class", 64'(tif.trace_class_o), 64'(0));
        check("rst_pc", 64'(tif.trace_pc_o), 64'(0));
        check("rst_instr", 64'(tif.trace_instr_o), 64'(0));
        check("rst_cnt", 64'(cnt_value_o), 64'(0));
        check("rst_unmatched", 64'(unmatched_cnt_o), 64'(0));
        check("rst_drop", 64'(drop_cnt_o), 64'(0));
        #2 rst_n = 1'b1;
        chk_en = 1'b1;
        tick();

        // ADDI / JAL classification and trace order
        program_slot(0, 32'h0000_707F, 32'h0000_0013, 1'b1);
        program_slot(1, 32'h0000_007F, 32'h0000_006F, 1'b1);
        check("pre_event_valid", 64'(tif.trace_valid_o), 64'(0));
        retire(ADDI, 32'h0000_1000);
        check("valid_one_cycle", 64'(tif.trace_valid_o), 64'(1));
        retire(JAL, 32'h0000_1004);
        peek_cnt("a_cnt0", 0, 1);
        peek_cnt("a_cnt1", 1, 1);
        check("a_unmatched", 64'(unmatched_cnt_o), 64'(0));
        pop_expect("a_e0", 0, 32'h0000_1000, ADDI);
        pop_expect("a_e1", 1, 32'h0000_1004, JAL);
        check("a_empty", 64'(tif.trace_valid_o), 64'(0));

        // Overlapping slots: both count, lowest index traced
        program_slot(2, 32'h0000_007F, 32'h0000_0013, 1'b1);
        retire(ADDI, 32'h0000_2000);
        peek_cnt("b_cnt0", 0, 2);
        peek_cnt("b_cnt2", 2, 1);
        pop_expect("b_e0", 0, 32'h0000_2000, ADDI);

        // Full FIFO: 6 hits with no consumer, then push+pop on full
        for (int i = 0; i < 6; i++) retire(ADDI, 32'h0000_3000 + 32'(4 * i));
        check("c_drop2", 64'(drop_cnt_o), 64'(2));
        check("c_head", 64'(tif.trace_pc_o), 64'(32'h0000_3000));
        tif.trace_ready_i = 1'b1;
        retire(ADDI, 32'h0000_3018);
        tif.trace_ready_i = 1'b0;
        check("c_drop_hold", 64'(drop_cnt_o), 64'(2));
        pop_expect("c_e0", 0, 32'h0000_3004, ADDI);
        pop_expect("c_e1", 0, 32'h0000_3008, ADDI);
        pop_expect("c_e2", 0, 32'h0000_300C, ADDI);
        pop_expect("c_e3", 0, 32'h0000_3018, ADDI);
        check("c_empty", 64'(tif.trace_valid_o), 64'(0));
        peek_cnt("c_cnt0", 0, 9);
        peek_cnt("c_cnt2", 2, 8);

        // Clear, saturation, clear beating a same-cycle hit
        cnt_clear_i = 1'b1;
        tick();
        cnt_clear_i = 1'b0;
        check("d_drop_clr", 64'(drop_cnt_o), 64'(0));
        peek_cnt("d_cnt0_clr", 0, 0);
        tif.trace_ready_i = 1'b1;
        for (int i = 0; i < 17; i++) retire(ADDI, 32'h0000_4000 + 32'(4 * i));
        tick();
        tick();
        tif.trace_ready_i = 1'b0;
        peek_cnt("d_sat0", 0, 15);
        peek_cnt("d_sat2", 2, 15);
        cnt_clear_i = 1'b1;
        retire(ADDI, 32'h0000_5000);
        cnt_clear_i = 1'b0;
        peek_cnt("d_clr_hit", 0, 0);
        pop_expect("d_e0", 0, 32'h0000_5000, ADDI);

        // Same-cycle config write uses the old configuration
        program_slot(2, 32'h0000_007F, 32'h0000_0013, 1'b0);
        cfg_we_i = 1'b1; cfg_idx_i = '0; cfg_en_i = 1'b0;
        cfg_mask_i = 32'h0000_707F; cfg_match_i = 32'h0000_0013;
        retire(ADDI, 32'h0000_6000);
        cfg_we_i = 1'b0;
        peek_cnt("e_cnt0_old", 0, 1);
        retire(ADDI, 32'h0000_6004);
        peek_cnt("e_cnt0_new", 0, 1);
        check("e_unmatched", 64'(unmatched_cnt_o), 64'(1));
        pop_expect("e_e0", 0, 32'h0000_6000, ADDI);
        check("e_empty", 64'(tif.trace_valid_o), 64'(0));

        // Freeze: no counting, no push
        program_slot(0, 32'h0000_707F, 32'h0000_0013, 1'b1);
        cnt_freeze_i = 1'b1;
        for (int i = 0; i < 3; i++) retire(ADDI, 32'h0000_7000 + 32'(4 * i));
        cnt_freeze_i = 1'b0;
        check("f_no_push", 64'(tif.trace_valid_o), 64'(0));
        peek_cnt("f_cnt0", 0, 1);
        check("f_unmatched", 64'(unmatched_cnt_o), 64'(1));

        // Asynchronous reset with two entries held
        retire(ADDI, 32'h0000_8000);
        retire(ADDI, 32'h0000_8004);
        check("h_valid_pre", 64'(tif.trace_valid_o), 64'(1));
        @(negedge clk);
        #2 rst_n = 1'b0;
        $display("async reset asserted");
        #1;
        check("h_valid_rst", 64'(tif.trace_valid_o), 64'(0));
        check("h_pc_rst", 64'(tif.trace_pc_o), 64'(0));
        check("h_cnt_rst", 64'(cnt_value_o), 64'(0));
        check("h_unm_rst", 64'(unmatched_cnt_o), 64'(0));
        check("h_drop_rst", 64'(drop_cnt_o), 64'(0));
        tick();
        #2 rst_n = 1'b1;
        tick();
        retire(ADDI, 32'h0000_9000);
        check("h_unm_after", 64'(unmatched_cnt_o), 64'(1));
        check("h_no_push", 64'(tif.trace_valid_o), 64'(0));
        peek_cnt("h_cnt0_unprog", 0, 0);
        program_slot(0, 32'h0000_707F, 32'h0000_0013, 1'b1);
        retire(ADDI, 32'h0000_9004);
        peek_cnt("h_cnt0_prog", 0, 1);
        pop_expect("h_e0", 0, 32'h0000_9004, ADDI);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
